fp_addsub_pipe: RTL and testbench
=================================

# fp_addsub_pipe

Parametrised, three-stage pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on both sides. It generalises the single-cycle FP add path in three ways. Exponent and mantissa widths are parameters, so one block covers binary32 and binary16. It handles signed operands and an explicit subtract request. It resolves zero, infinity and NaN cases and raises status flags. It sits between operand issue and writeback in the FP datapath and sustains one operation per clock when not back-pressured.

## Interface
- EXP_W, default 8: exponent field width (≥3).
- MAN_W, default 23: stored fraction width (≥4); word width W = 1+EXP_W+MAN_W.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; transfer when in_valid & in_ready at clk edge.
- in_a  in  W  operand A {sign, exp, frac}.
- in_b  in  W  operand B.
- in_sub  in  1  1 computes A−B; 0 computes A+B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- out_result  out  W  result word.
- out_flags  out  3  {nan, overflow, underflow}, qualified by out_valid.

## Operation
- Unpack: exp==0 means zero (subnormals flushed, sign kept); exp==all-ones & frac==0 means ±inf; exp==all-ones & frac≠0 means NaN. Normal hidden bit = 1.
- Effective B sign: sb' = sb ^ in_sub. Effective op: subtract iff sa ≠ sb'.
- Stage 1 (align): order operands by magnitude, comparing {exp,frac} unsigned. The larger operand is "big"; on a tie, A is big. d = exp_big − exp_small. The small mantissa (MAN_W+1 bits) is shifted right by d. Shifted-out bits are discarded (round toward zero). If d ≥ MAN_W+1, the small mantissa becomes 0.
- Stage 2 (add): sum = big_man ± small_man in MAN_W+2 bits. Result sign = sign of big (sb' if B is big).
- Stage 3 (normalise/pack):
  - If carry bit is set: shift right 1, exp+1, and drop the LSB.
  - Otherwise, if sum is nonzero: left-shift by the leading-zero count lz and set exp = exp_big − lz.
  - If sum == 0 (exact cancellation): result +0.
  - If the normalised exp ≤ 0: signed zero, underflow=1.
  - If the normalised exp ≥ all-ones: ±inf (exp all-ones, frac 0), overflow=1.
- Specials, decided in stage 1 and carried down the pipe; they override the arithmetic:
  - Any NaN input, or inf + (−inf) effective: canonical NaN = 0, exp all-ones, frac MSB 1, rest 0; nan=1.
  - One or two infinities of the same effective sign: that infinity, no flag.
  - Both operands zero: sign = sa & sb'.
  - Exactly one operand zero: the other operand passes unchanged (sign sb' if it is B).
- Flags are mutually exclusive and all 0 for ordinary results.

## Timing
- Three register stages s1/s2/s3, each with its own valid bit.
- Per-stage ready: ready_k = !valid_k | ready_{k+1}. ready_4 = out_ready, and in_ready = ready_1. Bubbles collapse.
- Latency: an operand accepted at edge N appears on out_result/out_valid after edge N+2 with no stall, i.e. 3 clocks from acceptance to consumable output.
- Throughput: 1 op/clock while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, s3 holds and out_result/out_flags stay stable. Upstream stages keep filling until full, then in_ready=0 combinationally.
- Simultaneous accept and release in the same cycle is permitted with no lost or duplicated op. Ordering is strictly FIFO.
- Reset (async, any time): all valid bits 0, out_valid=0, out_result=0, out_flags=0. in_ready=1 while rst_n=0 and after. In-flight operations are discarded; no output appears for them after release.
- in_a/in_b/in_sub are sampled only on accept. out_* are registered. in_ready is the only combinational output path (from out_ready).

## Test plan
- Default widths, no backpressure:
  - 0x3F800000 + 0x3F800000 → 0x40000000, flags 000, exactly 3 clocks after accept.
  - 0x40400000 − 0x3F800000 (in_sub=1) → 0x40000000.
  - 0x3FC00000 − 0x3FC00000 → 0x00000000, flags 000.
  - 0x3F800000 + 0x33800000 → 0x3F800000 (alignment truncation).
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags 010.
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, flags 100.
  - 0x00800001 − 0x00800000 → 0x00000000, flags 001.
- Backpressure: stream 8 back-to-back ops and hold out_ready=0 for 5 cycles mid-stream. in_ready must drop after 3 ops are buffered, output must stay stable while stalled, and all 8 results must arrive in order with none duplicated.
- Reset mid-operation: assert rst_n=0 with 3 ops in flight. out_valid=0 and out_result=0 immediately, with no stale output after release. A new op then completes normally.
- Half precision (EXP_W=5, MAN_W=10):
  - 0x3C00 + 0x3C00 → 0x4000.
  - 0x7BFF + 0x7BFF → 0x7C00, overflow=1.
  - 0x3C00 + 0xBC00 → 0x0000.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module : fp_addsub_pipe
// Three-stage pipelined floating-point add/subtract (flush-to-zero, truncating)
// with zero/inf/NaN resolution and valid/ready handshakes.
// Rev    : 1.0
// ============================================================================
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [2:0]             out_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int LZ_W = $clog2(MAN_W + 2);
  localparam int XW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

  localparam logic [EXP_W-1:0]     C_EXP_ONES = '1;
  localparam logic signed [XW-1:0] C_X_ZERO   = '0;
  localparam logic signed [XW-1:0] C_X_ONE    = XW'(1);
  localparam logic signed [XW-1:0] C_X_MAX    = XW'(C_EXP_ONES);

  // Unpack
  logic             w_sa, w_sb, w_eff_sub;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

  assign w_sa      = in_a[W-1];
  assign w_sb      = in_b[W-1] ^ in_sub;
  assign w_eff_sub = w_sa ^ w_sb;
  assign w_ea      = in_a[W-2:MAN_W];
  assign w_eb      = in_b[W-2:MAN_W];
  assign w_fa      = in_a[MAN_W-1:0];
  assign w_fb      = in_b[MAN_W-1:0];
  assign w_a_zero  = (w_ea == '0);
  assign w_b_zero  = (w_eb == '0);
  assign w_a_inf   = (w_ea == C_EXP_ONES) && (w_fa == '0);
  assign w_b_inf   = (w_eb == C_EXP_ONES) && (w_fb == '0);
  assign w_a_nan   = (w_ea == C_EXP_ONES) && (w_fa != '0);
  assign w_b_nan   = (w_eb == C_EXP_ONES) && (w_fb != '0);

  // Stage 1 alignment: A wins magnitude ties
  logic             w_a_big, w_sign;
  logic [EXP_W-1:0] w_e_big, w_e_small, w_d;
  logic [MAN_W:0]   w_m_big, w_m_small, w_m_small_sh;

  assign w_a_big      = (in_a[W-2:0] >= in_b[W-2:0]);
  assign w_sign       = w_a_big ? w_sa : w_sb;
  assign w_e_big      = w_a_big ? w_ea : w_eb;
  assign w_e_small    = w_a_big ? w_eb : w_ea;
  assign w_m_big      = {1'b1, (w_a_big ? w_fa : w_fb)};
  assign w_m_small    = {1'b1, (w_a_big ? w_fb : w_fa)};
  assign w_d          = w_e_big - w_e_small;
  assign w_m_small_sh = (32'(w_d) >= 32'(MAN_W + 1)) ? '0 : (w_m_small >> w_d);

  // Special-case result; overrides the arithmetic path when w_spec is set
  logic         w_spec;
  logic [W-1:0] w_spec_res;
  logic [2:0]   w_spec_flags;

  always_comb begin
    w_spec       = 1'b1;
    w_spec_res   = '0;
    w_spec_flags = 3'b000;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_eff_sub)) begin
      w_spec_res   = {1'b0, C_EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      w_spec_flags = 3'b100;
    end else if (w_a_inf) begin
      w_spec_res = {w_sa, C_EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec_res = {w_sb, C_EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_a_zero && w_b_zero) begin
      w_spec_res = {(w_sa & w_sb), {(W-1){1'b0}}};
    end else if (w_a_zero) begin
      w_spec_res = {w_sb, in_b[W-2:0]};
    end else if (w_b_zero) begin
      w_spec_res = in_a;
    end else begin
      w_spec = 1'b0;
    end
  end

  // Handshake: each stage advances when it is empty or its successor advances
  logic r_s1_valid, r_s2_valid, r_s3_valid;
  logic w_ready1, w_ready2, w_ready3;

  assign w_ready3  = !r_s3_valid || out_ready;
  assign w_ready2  = !r_s2_valid || w_ready3;
  assign w_ready1  = !r_s1_valid || w_ready2;
  assign in_ready  = w_ready1;
  assign out_valid = r_s3_valid;

  // Stage 1 registers
  logic             r_s1_spec, r_s1_sign, r_s1_eff_sub;
  logic [W-1:0]     r_s1_spec_res;
  logic [2:0]       r_s1_spec_flags;
  logic [EXP_W-1:0] r_s1_exp;
  logic [MAN_W:0]   r_s1_m_big, r_s1_m_small;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid      <= 1'b0;
      r_s1_spec       <= 1'b0;
      r_s1_spec_res   <= '0;
      r_s1_spec_flags <= 3'b000;
      r_s1_sign       <= 1'b0;
      r_s1_eff_sub    <= 1'b0;
      r_s1_exp        <= '0;
      r_s1_m_big      <= '0;
      r_s1_m_small    <= '0;
    end else if (w_ready1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_spec       <= w_spec;
        r_s1_spec_res   <= w_spec_res;
        r_s1_spec_flags <= w_spec_flags;
        r_s1_sign       <= w_sign;
        r_s1_eff_sub    <= w_eff_sub;
        r_s1_exp        <= w_e_big;
        r_s1_m_big      <= w_m_big;
        r_s1_m_small    <= w_m_small_sh;
      end
    end
  end

  // Stage 2: magnitude add/subtract; big >= small so the difference is never negative
  logic [MAN_W+1:0] w_sum;

  assign w_sum = r_s1_eff_sub ? ({1'b0, r_s1_m_big} - {1'b0, r_s1_m_small})
                              : ({1'b0, r_s1_m_big} + {1'b0, r_s1_m_small});

  logic             r_s2_spec, r_s2_sign;
  logic [W-1:0]     r_s2_spec_res;
  logic [2:0]       r_s2_spec_flags;
  logic [EXP_W-1:0] r_s2_exp;
  logic [MAN_W+1:0] r_s2_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid      <= 1'b0;
      r_s2_spec       <= 1'b0;
      r_s2_spec_res   <= '0;
      r_s2_spec_flags <= 3'b000;
      r_s2_sign       <= 1'b0;
      r_s2_exp        <= '0;
      r_s2_sum        <= '0;
    end else if (w_ready2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_spec       <= r_s1_spec;
        r_s2_spec_res   <= r_s1_spec_res;
        r_s2_spec_flags <= r_s1_spec_flags;
        r_s2_sign       <= r_s1_sign;
        r_s2_exp        <= r_s1_exp;
        r_s2_sum        <= w_sum;
      end
    end
  end

  // Stage 3: normalise and pack
  logic [LZ_W-1:0]      w_lz;
  logic [MAN_W-1:0]     w_frac_lsh, w_frac_n;
  logic signed [XW-1:0] w_exp_n;
  logic [W-1:0]         w_res;
  logic [2:0]           w_flags;

  // Highest set bit at or below the hidden-bit position sets the shift
  always_comb begin
    w_lz = '0;
    for (int i = 0; i <= MAN_W; i++) begin
      if (r_s2_sum[i]) w_lz = LZ_W'(MAN_W - i);
    end
  end

  assign w_frac_lsh = r_s2_sum[MAN_W-1:0] << w_lz;
  assign w_frac_n   = r_s2_sum[MAN_W+1] ? r_s2_sum[MAN_W:1] : w_frac_lsh;
  assign w_exp_n    = r_s2_sum[MAN_W+1] ? ($signed(XW'(r_s2_exp)) + C_X_ONE)
                                        : ($signed(XW'(r_s2_exp)) - $signed(XW'(w_lz)));

  always_comb begin
    w_res   = '0;
    w_flags = 3'b000;
    if (r_s2_spec) begin
      w_res   = r_s2_spec_res;
      w_flags = r_s2_spec_flags;
    end else if (r_s2_sum == '0) begin
      w_res = '0;
    end else if (w_exp_n <= C_X_ZERO) begin
      w_res   = {r_s2_sign, {(W-1){1'b0}}};
      w_flags = 3'b001;
    end else if (w_exp_n >= C_X_MAX) begin
      w_res   = {r_s2_sign, C_EXP_ONES, {MAN_W{1'b0}}};
      w_flags = 3'b010;
    end else begin
      w_res = {r_s2_sign, w_exp_n[EXP_W-1:0], w_frac_n};
    end
  end

  logic [W-1:0] r_out_result;
  logic [2:0]   r_out_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid   <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= 3'b000;
    end else if (w_ready3) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_result <= w_res;
        r_out_flags  <= w_flags;
      end
    end
  end

  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// Bench for fp_addsub_pipe: binary32 and binary16 instances, each with a queue
// scoreboard filled on accept and drained on output handshake.
module tb_fp_addsub_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_result;
  logic [2:0]  out_flags;

  logic        h_in_valid, h_in_ready, h_in_sub, h_out_valid, h_out_ready;
  logic [15:0] h_in_a, h_in_b, h_out_result;
  logic [2:0]  h_out_flags;

  fp_addsub_pipe u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_half (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (h_in_valid),
    .in_ready   (h_in_ready),
    .in_a       (h_in_a),
    .in_b       (h_in_b),
    .in_sub     (h_in_sub),
    .out_valid  (h_out_valid),
    .out_ready  (h_out_ready),
    .out_result (h_out_result),
    .out_flags  (h_out_flags)
  );

  logic [34:0] q[$];
  logic [34:0] hq[$];
  logic [34:0] m_e, h_e;
  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int k;
  logic [31:0] held;
  logic [2:0]  held_f;

  // fv[i] is the binary32 encoding of (i+1).0
  logic [31:0] fv [0:9] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                            32'h41100000, 32'h41200000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out32", 32'(out_valid), 32'd0);
      else begin
        m_e = q.pop_front();
        check("result32", out_result, m_e[31:0]);
        check("flags32", 32'(out_flags), 32'(m_e[34:32]));
      end
    end
  end

  always @(negedge clk) begin
    if (h_out_valid && h_out_ready) begin
      if (hq.size() == 0) check("spurious_out16", 32'(h_out_valid), 32'd0);
      else begin
        h_e = hq.pop_front();
        check("result16", 32'(h_out_result), h_e[31:0]);
        check("flags16", 32'(h_out_flags), 32'(h_e[34:32]));
      end
    end
  end

  // Entered and left at 1ns after a rising edge; returns after the accepting edge.
  task automatic send(input bit half, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic [31:0] er, input logic [2:0] ef);
    int   guard;
    logic rdy;
    guard = 0;
    if (half) begin
      h_in_a = a[15:0]; h_in_b = b[15:0]; h_in_sub = sub; h_in_valid = 1'b1;
    end else begin
      in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    end
    forever begin
      @(negedge clk);
      rdy = half ? h_in_ready : in_ready;
      if (rdy) begin
        if (half) hq.push_back({ef, er});
        else      q.push_back({ef, er});
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 50) begin
        check("send_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    in_valid   = 1'b0;
    h_in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q.size() != 0 || hq.size() != 0); i++) @(negedge clk);
    check("drain_empty", 32'(q.size() + hq.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_sub = 1'b0; h_out_ready = 1'b1;
    k = 0; held = '0; held_f = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_h_out_valid", 32'(h_out_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: visible after the second edge following accept
    send(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
    @(negedge clk); check("lat_edge1", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_edge2", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_edge3", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Arithmetic and specials, back-to-back
    send(0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
    send(0, 32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 3'b000);
    send(0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
    send(0, 32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 3'b000);
    send(0, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
    send(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010);
    send(0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
    send(0, 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);
    send(0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
    send(0, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
    send(0, 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000);
    send(0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    send(0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000);
    drain();

    // Backpressure: out_ready low for 5 cycles while 8 ops are offered
    out_ready = 1'b0;
    k = 0;
    in_a = fv[0]; in_b = fv[0]; in_sub = 1'b0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && k < 8; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_buffered", 32'(k), 32'd3);
        held   = out_result;
        held_f = out_flags;
      end
      if (cyc == 4) begin
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_result", out_result, held);
        check("bp_hold_flags", 32'(out_flags), 32'(held_f));
      end
      if (in_ready) begin
        q.push_back({3'b000, fv[k+1]});
        k++;
      end
      @(posedge clk); #1;
      if (k < 8) in_a = fv[k];
      else       in_valid = 1'b0;
      if (cyc == 4) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", 32'(k), 32'd8);
    drain();

    // Reset with three ops in flight
    out_ready = 1'b0;
    send(0, fv[0], fv[0], 1'b0, fv[1], 3'b000);
    send(0, fv[1], fv[0], 1'b0, fv[2], 3'b000);
    send(0, fv[2], fv[0], 1'b0, fv[3], 3'b000);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_result", out_result, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_idle", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    send(0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
    drain();

    // Half precision
    send(1, 32'h3C00, 32'h3C00, 1'b0, 32'h4000, 3'b000);
    send(1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 3'b010);
    send(1, 32'h3C00, 32'hBC00, 1'b0, 32'h0000, 3'b000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
